rpn_gw_to_network_bridge_merger: RTL



---
 rtl/rpn_gw_to_network_bridge_merger.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/rpn_gw_to_network_bridge_merger.sv
// Return-path merger: RPN LAN RX and RPN WAN TX streams into one AXIS stream
// toward the network bridge. Packet-atomic round-robin arbitration, a single
// registered output stage and per-source forwarded-packet counters.
module rpn_gw_to_network_bridge_merger #(
  parameter int AXIS_DATA_WIDTH  = 512,
  parameter int AXIS_KEEP_WIDTH  = 64,
  parameter int IP_PORT_WIDTH    = 16,
  parameter int AXIS_TUSER_WIDTH = 64,
  parameter int PKT_CNT_WIDTH    = 32
) (
  input  logic                        i_clk,
  input  logic                        i_ap_rst_n,

  input  logic                        from_rpn_LAN_RX_tvalid,
  output logic                        from_rpn_LAN_RX_tready,
  input  logic [AXIS_DATA_WIDTH-1:0]  from_rpn_LAN_RX_tdata,
  input  logic [AXIS_KEEP_WIDTH-1:0]  from_rpn_LAN_RX_tkeep,
  input  logic [IP_PORT_WIDTH-1:0]    from_rpn_LAN_RX_tid,
  input  logic [IP_PORT_WIDTH-1:0]    from_rpn_LAN_RX_tdest,
  input  logic [AXIS_TUSER_WIDTH-1:0] from_rpn_LAN_RX_tuser,
  input  logic                        from_rpn_LAN_RX_tlast,

  input  logic                        from_rpn_WAN_TX_tvalid,
  output logic                        from_rpn_WAN_TX_tready,
  input  logic [AXIS_DATA_WIDTH-1:0]  from_rpn_WAN_TX_tdata,
  input  logic [AXIS_KEEP_WIDTH-1:0]  from_rpn_WAN_TX_tkeep,
  input  logic [IP_PORT_WIDTH-1:0]    from_rpn_WAN_TX_tid,
  input  logic [IP_PORT_WIDTH-1:0]    from_rpn_WAN_TX_tdest,
  input  logic [AXIS_TUSER_WIDTH-1:0] from_rpn_WAN_TX_tuser,
  input  logic                        from_rpn_WAN_TX_tlast,

  output logic                        to_network_bridge_tvalid,
  input  logic                        to_network_bridge_tready,
  output logic [AXIS_DATA_WIDTH-1:0]  to_network_bridge_tdata,
  output logic [AXIS_KEEP_WIDTH-1:0]  to_network_bridge_tkeep,
  output logic [IP_PORT_WIDTH-1:0]    to_network_bridge_tid,
  output logic [IP_PORT_WIDTH-1:0]    to_network_bridge_tdest,
  output logic [AXIS_TUSER_WIDTH-1:0] to_network_bridge_tuser,
  output logic                        to_network_bridge_tlast,

  output logic [PKT_CNT_WIDTH-1:0]    o_lan_pkt_count,
  output logic [PKT_CNT_WIDTH-1:0]    o_wan_pkt_count
);

  typedef struct packed {
    logic [AXIS_DATA_WIDTH-1:0]  data;
    logic [AXIS_KEEP_WIDTH-1:0]  keep;
    logic [IP_PORT_WIDTH-1:0]    id;
    logic [IP_PORT_WIDTH-1:0]    dest;
    logic [AXIS_TUSER_WIDTH-1:0] user;
    logic                        last;
  } beat_t;

  typedef enum logic [1:0] {IDLE, LOCK_LAN, LOCK_WAN} state_t;

  state_t                   state;
  logic                     ptr_wan;    // 0: LAN has priority, 1: WAN has priority
  logic                     out_valid;
  beat_t                    out_q;
  logic [PKT_CNT_WIDTH-1:0] lan_cnt;
  logic [PKT_CNT_WIDTH-1:0] wan_cnt;

  beat_t lan_beat, wan_beat, sel_beat;
  logic  grant_lan, grant_wan, ld, lan_acc, wan_acc;

  assign lan_beat = '{data: from_rpn_LAN_RX_tdata, keep: from_rpn_LAN_RX_tkeep,
                      id: from_rpn_LAN_RX_tid, dest: from_rpn_LAN_RX_tdest,
                      user: from_rpn_LAN_RX_tuser, last: from_rpn_LAN_RX_tlast};
  assign wan_beat = '{data: from_rpn_WAN_TX_tdata, keep: from_rpn_WAN_TX_tkeep,
                      id: from_rpn_WAN_TX_tid, dest: from_rpn_WAN_TX_tdest,
                      user: from_rpn_WAN_TX_tuser, last: from_rpn_WAN_TX_tlast};

  // Output register can take a new beat when empty or being drained this cycle
  assign ld = !out_valid | to_network_bridge_tready;

  // Grant: free arbitration in IDLE, pinned to the owner while a packet is open
  always_comb begin
    grant_lan = 1'b0;
    grant_wan = 1'b0;
    case (state)
      IDLE: begin
        if (from_rpn_LAN_RX_tvalid && from_rpn_WAN_TX_tvalid) begin
          grant_lan = !ptr_wan;
          grant_wan = ptr_wan;
        end else begin
          grant_lan = from_rpn_LAN_RX_tvalid;
          grant_wan = from_rpn_WAN_TX_tvalid;
        end
      end
      LOCK_LAN: grant_lan = 1'b1;
      LOCK_WAN: grant_wan = 1'b1;
      default: ;
    endcase
  end

  // Reset gating keeps both treadys low while reset is held
  assign from_rpn_LAN_RX_tready = grant_lan & ld & i_ap_rst_n;
  assign from_rpn_WAN_TX_tready = grant_wan & ld & i_ap_rst_n;
  assign lan_acc  = from_rpn_LAN_RX_tvalid & from_rpn_LAN_RX_tready;
  assign wan_acc  = from_rpn_WAN_TX_tvalid & from_rpn_WAN_TX_tready;
  assign sel_beat = grant_wan ? wan_beat : lan_beat;

  // Output stage, arbitration state, priority pointer and packet counters
  always_ff @(posedge i_clk) begin
    if (!i_ap_rst_n) begin
      state     <= IDLE;
      ptr_wan   <= 1'b0;
      out_valid <= 1'b0;
      out_q     <= '0;
      lan_cnt   <= '0;
      wan_cnt   <= '0;
    end else begin
      if (ld) begin
        out_valid <= lan_acc | wan_acc;
        if (lan_acc | wan_acc) out_q <= sel_beat;
      end
      if (lan_acc) begin
        if (lan_beat.last) begin
          state   <= IDLE;
          ptr_wan <= 1'b1;
          lan_cnt <= lan_cnt + PKT_CNT_WIDTH'(1);
        end else begin
          state   <= LOCK_LAN;
        end
      end else if (wan_acc) begin
        if (wan_beat.last) begin
          state   <= IDLE;
          ptr_wan <= 1'b0;
          wan_cnt <= wan_cnt + PKT_CNT_WIDTH'(1);
        end else begin
          state   <= LOCK_WAN;
        end
      end
    end
  end

  assign to_network_bridge_tvalid = out_valid;
  assign to_network_bridge_tdata  = out_q.data;
  assign to_network_bridge_tkeep  = out_q.keep;
  assign to_network_bridge_tid    = out_q.id;
  assign to_network_bridge_tdest  = out_q.dest;
  assign to_network_bridge_tuser  = out_q.user;
  assign to_network_bridge_tlast  = out_q.last;
  assign o_lan_pkt_count          = lan_cnt;
  assign o_wan_pkt_count          = wan_cnt;

endmodule
